// File: rtl/stall_ctrl.sv
// Decode-stage hazard controller: register Tuse/Tnew stalls plus optional MDU busy tracking.
// Define STALL_MDU_TRACK_EN to include the multiply/divide busy counter and its hazard.
module stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  D_wa,
  input  logic [1:0]  D_tnew,
  input  logic        D_md_start,
  input  logic        D_md_div,
  input  logic        D_md_use,
  output logic        D_stall,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic [4:0]  r_e_wa;
  logic [1:0]  r_e_tnew;
  logic [4:0]  r_m_wa;
  logic [1:0]  r_m_tnew;
  logic [31:0] r_stall_cycles;

  logic w_haz_rs;
  logic w_haz_rt;
  logic w_haz_md;
  logic w_stall;

  // Tuse of 3 can never be exceeded by a Tnew of at most 2, so "never used" needs no special case.
  assign w_haz_rs = (D_rs != 5'd0) &&
                    (((D_rs == r_e_wa) && (r_e_tnew > D_tuse_rs)) ||
                     ((D_rs == r_m_wa) && (r_m_tnew > D_tuse_rs)));
  assign w_haz_rt = (D_rt != 5'd0) &&
                    (((D_rt == r_e_wa) && (r_e_tnew > D_tuse_rt)) ||
                     ((D_rt == r_m_wa) && (r_m_tnew > D_tuse_rt)));

  assign w_stall      = w_haz_rs | w_haz_rt | w_haz_md;
  assign D_stall      = w_stall;
  assign E_clr        = w_stall;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_wa         <= 5'd0;
      r_e_tnew       <= 2'd0;
      r_m_wa         <= 5'd0;
      r_m_tnew       <= 2'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_stall) begin
        r_e_wa   <= 5'd0;
        r_e_tnew <= 2'd0;
      end else begin
        r_e_wa   <= D_wa;
        r_e_tnew <= D_tnew;
      end
      r_m_wa   <= r_e_wa;
      r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
      if (w_stall)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

`ifdef STALL_MDU_TRACK_EN
  logic [3:0] r_md_cnt;

  assign md_busy  = (r_md_cnt != 4'd0);
  assign w_haz_md = D_md_use && md_busy;

  // A start blocked by a busy unit only loads once its stall releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_md_cnt <= 4'd0;
    else if (D_md_start && !w_stall)
      r_md_cnt <= D_md_div ? 4'd10 : 4'd5;
    else if (r_md_cnt != 4'd0)
      r_md_cnt <= r_md_cnt - 4'd1;
  end
`else
  logic w_unused_md;

  assign w_unused_md = ^{D_md_start, D_md_div, D_md_use};
  assign md_busy     = 1'b0;
  assign w_haz_md    = 1'b0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: load-use stalls, rs/rt/M-stage cases, counter wrap, MDU tracking.
// Covers both builds of STALL_MDU_TRACK_EN.
module tb_stall_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  D_rs = '0;
  logic [4:0]  D_rt = '0;
  logic [1:0]  D_tuse_rs = 2'd3;
  logic [1:0]  D_tuse_rt = 2'd3;
  logic [4:0]  D_wa = '0;
  logic [1:0]  D_tnew = '0;
  logic        D_md_start = 1'b0;
  logic        D_md_div = 1'b0;
  logic        D_md_use = 1'b0;
  logic        D_stall;
  logic        E_clr;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;

  stall_ctrl dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_wa(D_wa), .D_tnew(D_tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
    .D_stall(D_stall), .E_clr(E_clr), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] wa, input logic [1:0] tn,
                       input logic st, input logic dv, input logic us);
    D_rs = rs; D_rt = rt; D_tuse_rs = trs; D_tuse_rt = trt;
    D_wa = wa; D_tnew = tn; D_md_start = st; D_md_div = dv; D_md_use = us;
  endtask

  task automatic set_nop;
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    set_nop();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    set_nop();
    reset = 1'b1;
    #2;
    if (D_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", D_stall); end
    total++;
    if (E_clr !== 1'b0) begin bad++; $display("FAIL rst_eclr got=%0b exp=0", E_clr); end
    total++;
    if (md_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", md_busy); end
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", stall_cycles); end
    total++;
    reset = 1'b0;
    tick();
    // Shadow state is clear, so a tight consumer must not stall
    set_d(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    if (D_stall !== 1'b0) begin bad++; $display("FAIL rst_clean got=%0b exp=0", D_stall); end
    total++;
    tick();
  endtask

  task automatic test_load_alu;
    logic [1:0] exp_st [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      settle();
      if (D_stall !== exp_st[c][0]) begin bad++; $display("FAIL la_stall c=%0d got=%0b exp=%0b", c, D_stall, exp_st[c][0]); end
      total++;
      if (E_clr !== exp_st[c][0]) begin bad++; $display("FAIL la_eclr c=%0d got=%0b exp=%0b", c, E_clr, exp_st[c][0]); end
      total++;
      tick();
      if (c == 0) set_d(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    end
    set_nop();
    settle();
    if (stall_cycles !== 32'd1) begin bad++; $display("FAIL la_cnt got=%0d exp=1", stall_cycles); end
    total++;
  endtask

  task automatic test_load_branch;
    logic [1:0] exp_st [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      settle();
      if (D_stall !== exp_st[c][0]) begin bad++; $display("FAIL lb_stall c=%0d got=%0b exp=%0b", c, D_stall, exp_st[c][0]); end
      total++;
      tick();
      if (c == 0) set_d(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    set_nop();
    settle();
    if (stall_cycles !== 32'd2) begin bad++; $display("FAIL lb_cnt got=%0d exp=2", stall_cycles); end
    total++;
    // Same sequence, branch reads $0: never a hazard
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    if (D_stall !== 1'b0) begin bad++; $display("FAIL lb_zero got=%0b exp=0", D_stall); end
    total++;
    tick();
    set_nop();
    settle();
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL lb_zero_cnt got=%0d exp=0", stall_cycles); end
    total++;
  endtask

  task automatic test_rt_and_m;
    // lw $7 then store-like use of rt with Tuse 1: one stall from E
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd4, 5'd7, 2'd1, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    if (D_stall !== 1'b1) begin bad++; $display("FAIL rt_stall got=%0b exp=1", D_stall); end
    total++;
    tick();
    settle();
    if (D_stall !== 1'b0) begin bad++; $display("FAIL rt_release got=%0b exp=0", D_stall); end
    total++;
    tick();
    // Tuse 3 on matching register never stalls
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd7, 5'd7, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    if (D_stall !== 1'b0) begin bad++; $display("FAIL tuse3 got=%0b exp=0", D_stall); end
    total++;
    tick();
    // lw $9, nop, beq $9: producer in M with Tnew 1 > Tuse 0 -> one stall
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_nop();
    tick();
    set_d(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    if (D_stall !== 1'b1) begin bad++; $display("FAIL m_stall got=%0b exp=1", D_stall); end
    total++;
    tick();
    settle();
    if (D_stall !== 1'b0) begin bad++; $display("FAIL m_release got=%0b exp=0", D_stall); end
    total++;
    tick();
    set_nop();
  endtask

  task automatic test_wrap;
    do_reset();
    @(negedge clk);
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    tick();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    if (stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got=%0h exp=ffffffff", stall_cycles); end
    total++;
    tick();
    settle();
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL wrap_zero got=%0h exp=0", stall_cycles); end
    total++;
    tick();
    set_nop();
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    if (D_stall !== 1'b0) begin bad++; $display("FAIL rms_stall got=%0b exp=0", D_stall); end
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rms_cnt got=%0d exp=0", stall_cycles); end
    total++;
    reset = 1'b0;
    set_nop();
    tick();
  endtask

`ifdef STALL_MDU_TRACK_EN
  task automatic test_mdu_op(input logic is_div, input int lat);
    do_reset();
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
    settle();
    if (D_stall !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL md_start div=%0b stall=%0b busy=%0b exp=0,0", is_div, D_stall, md_busy); end
    total++;
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= lat + 1; c++) begin
      settle();
      if (D_stall !== (c <= lat)) begin bad++; $display("FAIL md_stall div=%0b c=%0d got=%0b exp=%0b", is_div, c, D_stall, c <= lat); end
      total++;
      if (md_busy !== (c <= lat)) begin bad++; $display("FAIL md_busy div=%0b c=%0d got=%0b exp=%0b", is_div, c, md_busy, c <= lat); end
      total++;
      tick();
    end
    set_nop();
    settle();
    if (stall_cycles !== 32'(lat)) begin bad++; $display("FAIL md_cnt div=%0b got=%0d exp=%0d", is_div, stall_cycles, lat); end
    total++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= 6; c++) begin
      settle();
      if (D_stall !== (c <= 5)) begin bad++; $display("FAIL b2b_stall c=%0d got=%0b exp=%0b", c, D_stall, c <= 5); end
      total++;
      tick();
    end
    set_nop();
    for (int c = 1; c <= 6; c++) begin
      settle();
      if (md_busy !== (c <= 5)) begin bad++; $display("FAIL b2b_busy c=%0d got=%0b exp=%0b", c, md_busy, c <= 5); end
      total++;
      tick();
    end
    if (stall_cycles !== 32'd5) begin bad++; $display("FAIL b2b_cnt got=%0d exp=5", stall_cycles); end
    total++;
  endtask

  task automatic test_reset_mid_div;
    do_reset();
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    settle();
    if (D_stall !== 1'b1) begin bad++; $display("FAIL rmd_pre got=%0b exp=1", D_stall); end
    total++;
    #1;
    reset = 1'b1;
    #1;
    if (D_stall !== 1'b0) begin bad++; $display("FAIL rmd_stall got=%0b exp=0", D_stall); end
    total++;
    if (md_busy !== 1'b0) begin bad++; $display("FAIL rmd_busy got=%0b exp=0", md_busy); end
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rmd_cnt got=%0d exp=0", stall_cycles); end
    total++;
    reset = 1'b0;
    set_nop();
    tick();
  endtask
`else
  task automatic test_mdu_disabled;
    do_reset();
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      settle();
      if (D_stall !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL nomd c=%0d stall=%0b busy=%0b exp=0,0", c, D_stall, md_busy); end
      total++;
      tick();
    end
    set_nop();
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL nomd_cnt got=%0d exp=0", stall_cycles); end
    total++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_alu();
    test_load_branch();
    test_rt_and_m();
    test_wrap();
    test_reset_mid_stall();
`ifdef STALL_MDU_TRACK_EN
    test_mdu_op(1'b1, 10);
    test_mdu_op(1'b0, 5);
    test_back_to_back();
    test_reset_mid_div();
`else
    test_mdu_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
